pio_in_edge_irq: RTL and testbench

Avalon-MM slave input port, the read-side counterpart of the board output PIOs. It samples board inputs such as KEY and SW, then synchronizes and debounces each bit. It captures the configured edges into sticky bits and raises a level interrupt to the Nios II. Zero-wait-state register file on the same slave bus as the output PIOs.

---
 rtl/pio_pkg.sv | 14 +
 rtl/pio_in_edge_irq_if.sv | 20 ++
 rtl/pio_in_debounce.sv | 55 +++++
 rtl/pio_in_edge_irq.sv | 80 ++++++++
 tb/tb_pio_in_edge_irq.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared register addresses and edge-select encodings for the board PIO blocks.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus shared by the board PIO register files.
interface pio_in_edge_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_in_debounce.sv
// One input bit: two-flop synchronizer followed by a hold-time debounce filter.
module pio_in_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o,
  output logic update_o,
  output logic new_level_o
);

  localparam int DEFF = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(DEFF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEFF - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= RESET_LEVEL;
      s2_q     <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= in_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle where the synchronized input agrees with stable restarts the hold count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    update_o = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      update_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign stable_o    = stable_q;
  assign new_level_o = s2_q;

endmodule

// File: rtl/pio_in_edge_irq.sv
// Debounced input PIO with sticky edge capture, interrupt mask and a level irq.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int              WIDTH           = 4,
  parameter edge_type_e      EDGE_TYPE       = EDGE_FALL,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  pio_in_edge_irq_if.slave bus,
  output logic             irq
);

  logic [WIDTH-1:0] stable, update, newLevel, edgeSet;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] capClear;
  logic             wrEn;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[g])
    ) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_i       (in_port[g]),
      .stable_o   (stable[g]),
      .update_o   (update[g]),
      .new_level_o(newLevel[g])
    );
  end

  // Edges come from the pending debounce update so capture lands with the stable change.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edgeSet = update & newLevel;
      EDGE_FALL: edgeSet = update & ~newLevel;
      default:   edgeSet = update;
    endcase
  end

  assign wrEn = bus.chipselect && !bus.write_n;

  always_comb begin
    irq_mask_d = irq_mask_q;
    capClear   = '0;
    if (wrEn && bus.address == ADDR_IRQ_MASK) irq_mask_d = bus.writedata[WIDTH-1:0];
    if (wrEn && bus.address == ADDR_EDGE_CAP) capClear = bus.writedata[WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~capClear) | edgeSet;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:     bus.readdata[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: bus.readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: bus.readdata[WIDTH-1:0] = edge_cap_q;
      default:       bus.readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

  wire unused_wdata = &{1'b0, bus.writedata};

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: debounce, falling-edge capture, W1C and irq.
module tb_pio_in_edge_irq;
  import pio_pkg::*;

  logic        clk;
  logic        resetN;
  logic [3:0]  inPort;
  logic        irq;
  logic [31:0] d;
  int          checks = 0;
  int          errors = 0;

  pio_in_edge_irq_if bus ();

  pio_in_edge_irq #(
    .WIDTH          (4),
    .EDGE_TYPE      (EDGE_FALL),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL    (4'hF)
  ) dut (
    .clk    (clk),
    .reset_n(resetN),
    .in_port(inPort),
    .bus    (bus),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] data);
    bus.address = a;
    #1;
    data = bus.readdata;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] data);
    bus.address    = a;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
  endtask

  task automatic test_reset();
    resetN         = 1'b0;
    inPort         = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    tick(3);
    resetN = 1'b1;
    readReg(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL reset_data actual=%h expected=%h", d, 32'hF); end
    readReg(2'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsvd actual=%h expected=%h", d, 32'h0); end
    readReg(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_mask actual=%h expected=%h", d, 32'h0); end
    readReg(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_cap actual=%h expected=%h", d, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq actual=%b expected=0", irq); end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      readReg(2'd3, d); checks++;
      if (d !== 32'h0 || irq !== 1'b0)
        begin errors++; $display("[TB] FAIL idle_cycle%0d actual cap=%h irq=%b expected cap=0 irq=0", i, d, irq); end
    end
  endtask

  task automatic test_falling_edge();
    inPort = 4'hE;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      readReg(2'd0, d); checks++;
      if (d !== 32'hF) begin errors++; $display("[TB] FAIL fall_hold_k%0d actual=%h expected=%h", i, d, 32'hF); end
    end
    tick(1);
    readReg(2'd0, d); checks++;
    if (d !== 32'hE) begin errors++; $display("[TB] FAIL fall_data actual=%h expected=%h", d, 32'hE); end
    readReg(2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL fall_cap actual=%h expected=%h", d, 32'h1); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL fall_irq_unmasked actual=%b expected=0", irq); end
    writeReg(ADDR_IRQ_MASK, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL mask_irq actual=%b expected=1", irq); end
  endtask

  task automatic test_glitch();
    inPort = 4'hC;
    tick(3);
    inPort = 4'hE;
    tick(10);
    readReg(2'd0, d); checks++;
    if (d !== 32'hE) begin errors++; $display("[TB] FAIL glitch_data actual=%h expected=%h", d, 32'hE); end
    readReg(2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL glitch_cap actual=%h expected=%h", d, 32'h1); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL glitch_irq actual=%b expected=1", irq); end
  endtask

  task automatic test_w1c();
    inPort = 4'hC;
    tick(7);
    readReg(2'd3, d); checks++;
    if (d !== 32'h3) begin errors++; $display("[TB] FAIL w1c_pre_cap actual=%h expected=%h", d, 32'h3); end
    writeReg(ADDR_IRQ_MASK, 32'h2);
    writeReg(ADDR_EDGE_CAP, 32'h1);
    readReg(2'd3, d); checks++;
    if (d !== 32'h2) begin errors++; $display("[TB] FAIL w1c_bit0 actual=%h expected=%h", d, 32'h2); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL w1c_irq_kept actual=%b expected=1", irq); end
    writeReg(ADDR_EDGE_CAP, 32'h2);
    readReg(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL w1c_bit1 actual=%h expected=%h", d, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL w1c_irq_drop actual=%b expected=0", irq); end
  endtask

  task automatic test_collision();
    inPort = 4'hD;
    tick(8);
    readReg(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL rise_ignored actual=%h expected=%h", d, 32'h0); end
    inPort = 4'hC;
    tick(5);
    writeReg(ADDR_EDGE_CAP, 32'h1);
    readReg(2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL collide_cap actual=%h expected=%h", d, 32'h1); end
    readReg(2'd0, d); checks++;
    if (d !== 32'hC) begin errors++; $display("[TB] FAIL collide_data actual=%h expected=%h", d, 32'hC); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL collide_irq actual=%b expected=0", irq); end
  endtask

  task automatic test_reset_mid();
    inPort = 4'hF;
    tick(8);
    inPort = 4'hB;
    tick(4);
    resetN = 1'b0;
    readReg(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL mid_rst_data actual=%h expected=%h", d, 32'hF); end
    readReg(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_mask actual=%h expected=%h", d, 32'h0); end
    readReg(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_cap actual=%h expected=%h", d, 32'h0); end
    tick(1);
    resetN = 1'b1;
    tick(5);
    readReg(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL redeb_hold actual=%h expected=%h", d, 32'hF); end
    tick(1);
    readReg(2'd0, d); checks++;
    if (d !== 32'hB) begin errors++; $display("[TB] FAIL redeb_data actual=%h expected=%h", d, 32'hB); end
    readReg(2'd3, d); checks++;
    if (d !== 32'h4) begin errors++; $display("[TB] FAIL redeb_cap actual=%h expected=%h", d, 32'h4); end
    inPort = 4'hF;
    tick(10);
    readReg(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL rise2_data actual=%h expected=%h", d, 32'hF); end
    readReg(2'd3, d); checks++;
    if (d !== 32'h4) begin errors++; $display("[TB] FAIL rise2_cap actual=%h expected=%h", d, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_falling_edge();
    test_glitch();
    test_w1c();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
